uart_cmd_wrapper: RTL and testbench

- DUT-side endpoint of the remote command link.
- Receives 16-bit commands as two UART bytes (high byte first) from the remote-control transmitter, assembles them, and presents `cmd` with a `cmd_rdy` flag to the command processor.
- Serialises 8-bit response bytes (acknowledges, e.g. 0xA5) back over TX.
- Contains its own bit-level UART RX and TX engines: 8N1, LSB first. RX and TX are full duplex and independent.

---
 rtl/uart_cmd_wrapper.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// Remote command link endpoint: 8N1 UART RX assembles two-byte commands, TX serialises response bytes.
// state      | meaning
// RX_IDLE    | waiting for synchronised falling edge on RX
// RX_RECV    | sampling start, 8 data and stop bits mid-bit
// ASM_HIGH   | next received byte is cmd[15:8]
// ASM_LOW    | next received byte is cmd[7:0]
// TX_IDLE    | line high, waiting for trmt
// TX_XMIT    | shifting the 10-bit frame out LSB first
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic {RX_IDLE, RX_RECV}   rx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW}  asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT}   tx_state_t;

  rx_state_t   r_rx_state;
  asm_state_t  r_asm_state;
  tx_state_t   r_tx_state;

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bits;
  logic [7:0]    r_rx_shift;
  logic          r_byte_rdy;
  logic [CW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bits;
  logic [9:0]    r_tx_shift;
  logic          w_rx_start;

  // Synchroniser flops preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_start = r_rx_s3 & ~r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_byte_rdy <= 1'b0;
    end else begin
      r_byte_rdy <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_start) begin
            r_rx_state <= RX_RECV;
            r_rx_baud  <= BAUD_HALF;
            r_rx_bits  <= '0;
          end
        end
        RX_RECV: begin
          if (r_rx_baud == ONE) begin
            r_rx_baud <= BAUD_FULL;
            // Only the eight data samples enter the shifter; start and stop are dropped.
            if (r_rx_bits != 4'd0 && r_rx_bits != 4'd9)
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bits == 4'd9) begin
              r_byte_rdy <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_bits <= r_rx_bits + 4'd1;
            end
          end else begin
            r_rx_baud <= r_rx_baud - ONE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A new byte takes priority over clr_cmd_rdy, so a set on the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_state <= ASM_HIGH;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
    end else if (r_byte_rdy) begin
      case (r_asm_state)
        ASM_HIGH: begin
          cmd[15:8]   <= r_rx_shift;
          cmd_rdy     <= 1'b0;
          r_asm_state <= ASM_LOW;
        end
        default: begin
          cmd[7:0]    <= r_rx_shift;
          cmd_rdy     <= 1'b1;
          r_asm_state <= ASM_HIGH;
        end
      endcase
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '1;
      tx_done    <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (trmt) begin
            r_tx_shift <= {1'b1, resp, 1'b0};
            r_tx_baud  <= BAUD_FULL;
            r_tx_bits  <= '0;
            tx_done    <= 1'b0;
            r_tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (r_tx_baud == ONE) begin
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            r_tx_baud  <= BAUD_FULL;
            if (r_tx_bits == 4'd9) begin
              tx_done    <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_bits <= r_tx_bits + 4'd1;
            end
          end else begin
            r_tx_baud <= r_tx_baud - ONE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX = r_tx_shift[0];

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: drives RX frames, decodes TX frames, scoreboards commands and responses.
module tb_uart_cmd_wrapper;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        tx_done;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] q_cmd[$];
  logic [7:0]  q_tx[$];

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .trmt(trmt), .resp(resp), .tx_done(tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Remote transmitter: drives the first nbits of an 8N1 frame, each held BD clocks.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      RX = frame[i];
      repeat (BD) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 10);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    logic [15:0] exp;
    q_cmd.push_back(c);
    send_byte(c[15:8]);
    check("hi_byte_rdy_low", cmd_rdy, 0);
    send_byte(c[7:0]);
    exp = (q_cmd.size() > 0) ? q_cmd.pop_front() : 16'hxxxx;
    check("cmd_value", cmd, exp);
    check("cmd_rdy_set", cmd_rdy, 1);
  endtask

  // Pulses trmt, optionally re-pulses it at clk 40 of the frame, and decodes TX mid-bit.
  task automatic send_resp(input logic [7:0] b, input bit inject, input logic [7:0] ib);
    logic [9:0] got;
    logic [7:0] exp;
    got = '0;
    q_tx.push_back(b);
    trmt = 1'b1;
    resp = b;
    for (int k = 1; k <= 161; k++) begin
      @(negedge clk);
      if (k == 1) begin
        trmt = 1'b0;
        resp = 8'h00;
        check("tx_done_clr", tx_done, 0);
      end
      if (inject && k == 40) begin
        trmt = 1'b1;
        resp = ib;
      end
      if (inject && k == 41) trmt = 1'b0;
      if ((k % BD) == BD / 2 && (k / BD) < 10) got[k / BD] = TX;
      if (k == 160) check("tx_done_early", tx_done, 0);
      if (k == 161) check("tx_done_set", tx_done, 1);
    end
    exp = (q_tx.size() > 0) ? q_tx.pop_front() : 8'hxx;
    check("tx_start_bit", got[0], 0);
    check("tx_stop_bit", got[9], 1);
    check("tx_byte", got[8:1], exp);
  endtask

  initial begin
    int lows;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_tx_done", tx_done, 0);

    send_cmd(16'h2015);
    repeat (20) @(negedge clk);
    check("cmd_rdy_hold", cmd_rdy, 1);
    check("cmd_hold", cmd, 16'h2015);

    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("clr_cmd_rdy", cmd_rdy, 0);
    check("clr_keeps_cmd", cmd, 16'h2015);

    send_cmd(16'h4002);
    send_byte(8'h60);
    check("overwrite_rdy_drop", cmd_rdy, 0);
    check("overwrite_hi", cmd[15:8], 8'h60);
    check("overwrite_lo_kept", cmd[7:0], 8'h02);
    send_byte(8'h00);
    check("overwrite_cmd", cmd, 16'h6000);
    check("overwrite_rdy", cmd_rdy, 1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;

    send_resp(8'hA5, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    check("tx_idle_high", TX, 1);
    check("tx_done_held", tx_done, 1);

    send_resp(8'hA5, 1'b1, 8'h5A);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    check("no_second_frame", lows, 0);
    send_resp(8'h5A, 1'b0, 8'h00);

    fork
      send_cmd(16'h3F0C);
      send_resp(8'hA5, 1'b0, 8'h00);
    join
    repeat (4) @(negedge clk);

    send_byte(8'h11);
    check("mid_hi_rdy_low", cmd_rdy, 0);
    trmt = 1'b1;
    resp = 8'h00;
    @(negedge clk);
    trmt = 1'b0;
    send_bits(8'h99, 4);
    check("tx_busy_low", TX, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", TX, 1);
    check("rst_mid_cmd_rdy", cmd_rdy, 0);
    check("rst_mid_cmd", cmd, 16'h0000);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_cmd(16'h2233);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
